// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// the latched request record and the accept-time error check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  // Only the byte lane survives past accept; the word address lives in mem_address.
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic lsu_req_error(input logic        write,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr,
                                         input logic [31:0] mem_words);
    logic illegal, misaligned, out_of_range;
    if (write) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else       illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= mem_words);
    return illegal | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: sub-word load extract/extend and sub-word
// store merge into the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [3:0][7:0]  bytes, merged_b;
  logic [1:0][15:0] halves, merged_h;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;

  always_comb begin
    bytes  = word;
    halves = word;
    sel_b  = bytes[lane];
    sel_h  = halves[lane[1]];

    case (funct3)
      F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
      F3_BU:   load_data = {24'b0, sel_b};
      F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
      F3_HU:   load_data = {16'b0, sel_h};
      default: load_data = word;
    endcase

    merged_b           = word;
    merged_b[lane]     = wdata[7:0];
    merged_h           = word;
    merged_h[lane[1]]  = wdata[15:0];

    case (funct3[1:0])
      2'b00:   store_data = merged_b;
      2'b01:   store_data = merged_h;
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-only data memory with
// async read and sync write; sub-word stores go through read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data, store_data;

  lsu_lane_align u_align (
    .funct3     (req_q.funct3),
    .lane       (req_q.lane),
    .word       (mem_read_data),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Every output is registered: next-cycle values are decided here per state.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;

    case (state_q)
      LSU_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_d       = '{write: req_write, funct3: req_funct3,
                          lane: req_address[1:0], wdata: req_wdata};
          req_ready_d = 1'b0;
          if (lsu_req_error(req_write, req_funct3, req_address, MEM_WORDS_L)) begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && (req_funct3 == F3_W)) begin
            state_d     = LSU_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = {req_address[31:2], 2'b00};
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = LSU_READ;
            mem_addr_d = {req_address[31:2], 2'b00};
          end
        end
      end
      LSU_READ: begin
        if (req_q.write) begin
          state_d     = LSU_WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = store_data;
        end else begin
          state_d      = LSU_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      LSU_WRITE: begin
        state_d      = LSU_RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d     = LSU_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LSU_IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random traffic against an
// arithmetic reference model of memory, and reset corner sequences.
module tb_load_store_unit;

  localparam int MW = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];

  int nvec = 0;
  int nerr = 0;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clock) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Reference: size/sign from funct3, shift-and-mask arithmetic on a word array.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output int lat);
    int unsigned idx  = a >> 2;
    int unsigned lane = a % 4;
    int unsigned size;
    logic [31:0] mask, word, val;
    bit legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    rd   = 0;
    err  = !legal || (a % size != 0) || (idx >= MW);
    lat  = 1;
    if (err) return;
    word = ref_mem[idx];
    if (!w) begin
      val = (word >> (8 * lane)) & mask;
      if (f3 < 4 && size < 4 && val[8*size-1]) val = val | ~mask;
      rd  = val;
      lat = 2;
    end else begin
      ref_mem[idx] = (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      lat = (size == 4) ? 2 : 3;
    end
  endfunction

  function automatic void check_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(name, diffs, 0);
  endfunction

  // Issue one request, keep req_valid high with junk while busy, measure the response.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int we_cnt);
    int misal = 0;
    bit got = 0;
    @(negedge clock);
    check("ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
    @(posedge clock);
    #1;
    req_write = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_address = $urandom; req_wdata = $urandom;
    lat = 0; we_cnt = 0; rd = 'x; err = 'x;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      lat++;
      if (mem_write_enable) we_cnt++;
      if (mem_address[1:0] != 2'b00) misal++;
      if (resp_valid) begin
        got = 1; rd = resp_rdata; err = resp_error;
        check("idle_addr_in_resp", mem_address, 32'h0);
        check("idle_wdata_in_resp", mem_write_data, 32'h0);
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
    check("addr_word_aligned", misal, 0);
    @(negedge clock);
    check("ready_after", req_ready, 1'b1);
    check("single_resp_pulse", resp_valid, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          lat, exp_lat, we_cnt;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    for (int i = 0; i < MW; i++) begin
      mem[i] = $urandom;
    end
    mem[5] = 32'h8899AABB; mem[3] = 32'h11223344; mem[63] = 32'h0BADF00D;
    for (int i = 0; i < MW; i++) ref_mem[i] = mem[i];

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_error", resp_error, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", mem_write_enable, 1'b0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    reset = 1'b0;

    vecs = '{
      '{0, 3'b000, 32'h15,  32'h0,        32'hFFFFFFAA, 0, 2},
      '{0, 3'b100, 32'h15,  32'h0,        32'h000000AA, 0, 2},
      '{0, 3'b001, 32'h16,  32'h0,        32'hFFFF8899, 0, 2},
      '{0, 3'b101, 32'h16,  32'h0,        32'h00008899, 0, 2},
      '{1, 3'b000, 32'h0E,  32'h000000EE, 32'h0,        0, 3},
      '{0, 3'b010, 32'h0C,  32'h0,        32'h11EE3344, 0, 2},
      '{1, 3'b010, 32'h20,  32'hDEADBEEF, 32'h0,        0, 2},
      '{0, 3'b010, 32'h20,  32'h0,        32'hDEADBEEF, 0, 2},
      '{1, 3'b001, 32'h21,  32'h0000CAFE, 32'h0,        1, 1},
      '{0, 3'b010, 32'h20,  32'h0,        32'hDEADBEEF, 0, 2},
      '{0, 3'b010, 32'h100, 32'h0,        32'h0,        1, 1},
      '{0, 3'b011, 32'h20,  32'h0,        32'h0,        1, 1},
      '{1, 3'b100, 32'h20,  32'h0,        32'h0,        1, 1},
      '{0, 3'b010, 32'hFC,  32'h0,        32'h0BADF00D, 0, 2},
      '{0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 1},
      '{1, 3'b001, 32'h16,  32'hFFFF1234, 32'h0,        0, 3},
      '{0, 3'b010, 32'h14,  32'h0,        32'h1234AABB, 0, 2},
      '{0, 3'b000, 32'h17,  32'h0,        32'h00000012, 0, 2}
    };

    foreach (vecs[i]) begin
      do_req(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, we_cnt);
      model(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err, exp_lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_error", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_we_cycles", i), we_cnt,
            (vecs[i].write && !vecs[i].exp_err) ? 1 : 0);
      check_mem($sformatf("vec%0d_memory", i));
    end

    for (int n = 0; n < 300; n++) begin
      w  = $urandom_range(0, 1);
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, MW * 4 + 15);
      wd = $urandom;
      do_req(w, f3, a, wd, rd, err, lat, we_cnt);
      model(w, f3, a, wd, exp_rd, exp_err, exp_lat);
      check("rand_rdata", rd, exp_rd);
      check("rand_error", err, exp_err);
      check("rand_latency", lat, exp_lat);
      check("rand_we_cycles", we_cnt, (w && !exp_err) ? 1 : 0);
      check_mem("rand_memory");
    end

    // Reset lands on the READ->WRITE edge of an SB: the write must be dropped.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_address = 32'h09; req_wdata = 32'h00000055;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rmw_in_read", mem_write_enable, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("rmw_rst_ready", req_ready, 1'b1);
    check("rmw_rst_resp", resp_valid, 1'b0);
    check("rmw_rst_we", mem_write_enable, 1'b0);
    reset = 1'b0;
    we_cnt = 0; lat = 0;
    repeat (5) begin
      @(negedge clock);
      if (mem_write_enable) we_cnt++;
      if (resp_valid) lat++;
    end
    check("rmw_rst_no_write_after", we_cnt, 0);
    check("rmw_rst_no_resp_after", lat, 0);
    check_mem("rmw_rst_memory");

    // Reset and req_valid together: no accept.
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h20;
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_req_no_read", mem_address, 32'h0);
    we_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) we_cnt++;
    end
    check("rst_req_no_resp", we_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
